// File: rtl/jt6295_seqn.sv
`default_nettype none
// ============================================================================
//  Module   : jt6295_seqn
//  Purpose  : Time-multiplexed ADPCM channel sequencer; fetches one nibble
//             per channel slot and feeds the shared decoder pipe.
//  Revision : 1.0  initial release
// ============================================================================
module jt6295_seqn #(
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int AW  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    stop,
    input  logic [NCH-1:0]    loop,
    input  logic [NCH*AW-1:0] start_addr,
    input  logic [NCH*AW-1:0] stop_addr,
    input  logic [NCH*4-1:0]  att,
    output logic [AW-1:0]     rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done,
    output logic              pipe_en,
    output logic              pipe_first,
    output logic [CW-1:0]     pipe_ch,
    output logic [3:0]        pipe_data,
    output logic [3:0]        pipe_att
);

    localparam logic [CW-1:0] c_last = CW'(NCH - 1);

    logic [AW-1:0] w_start [NCH];
    logic [AW-1:0] w_stop  [NCH];
    logic [3:0]    w_att   [NCH];

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_unpack
            assign w_start[g] = start_addr[g*AW +: AW];
            assign w_stop[g]  = stop_addr[g*AW +: AW];
            assign w_att[g]   = att[g*4 +: 4];
        end
    endgenerate

    logic [CW-1:0]  r_slot;
    logic [NCH-1:0] r_busy;
    logic [NCH-1:0] r_done;
    logic [NCH-1:0] r_first;
    logic [NCH-1:0] r_loop;
    logic [NCH-1:0] r_pend_start;
    logic [NCH-1:0] r_pend_stop;
    logic [AW:0]    r_nib [NCH];
    logic [AW-1:0]  r_rom_addr;
    logic           r_pipe_en;
    logic           r_pipe_first;
    logic [CW-1:0]  r_pipe_ch;
    logic [3:0]     r_pipe_data;
    logic [3:0]     r_pipe_att;

    logic [CW-1:0]  w_next;
    logic [NCH-1:0] w_clr;
    logic [AW:0]    w_exit_nib;
    logic           w_exit_end;
    logic           w_load;

    always_comb begin
        w_next = (r_slot == c_last) ? '0 : r_slot + CW'(1);
        w_clr  = '0;
        if (cen) begin
            w_clr[w_next] = 1'b1;
        end
        w_exit_nib = r_nib[r_slot];
        // End of sample: low nibble of the inclusive last byte
        w_exit_end = w_exit_nib[0] && (w_exit_nib[AW:1] == w_stop[r_slot]);
        w_load     = r_pend_start[w_next] && !r_pend_stop[w_next] && !r_busy[w_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot       <= '0;
            r_busy       <= '0;
            r_done       <= '0;
            r_first      <= '0;
            r_loop       <= '0;
            r_pend_start <= '0;
            r_pend_stop  <= '0;
            r_rom_addr   <= '0;
            r_pipe_en    <= 1'b0;
            r_pipe_first <= 1'b0;
            r_pipe_ch    <= '0;
            r_pipe_data  <= '0;
            r_pipe_att   <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_nib[i] <= '0;
            end
        end else begin
            r_done       <= '0;
            // Requests arriving on the clearing edge survive to the next period
            r_pend_start <= (r_pend_start & ~w_clr) | start;
            r_pend_stop  <= (r_pend_stop  & ~w_clr) | stop;
            if (cen) begin
                r_slot       <= w_next;
                r_pipe_ch    <= r_slot;
                r_pipe_att   <= w_att[r_slot];
                r_pipe_en    <= 1'b0;
                r_pipe_first <= 1'b0;
                if (r_busy[r_slot] && rom_ok) begin
                    r_pipe_en      <= 1'b1;
                    r_pipe_data    <= w_exit_nib[0] ? rom_data[3:0] : rom_data[7:4];
                    r_pipe_first   <= r_first[r_slot];
                    r_first[r_slot] <= 1'b0;
                    if (w_exit_end) begin
                        if (r_loop[r_slot]) begin
                            r_nib[r_slot]   <= {w_start[r_slot], 1'b0};
                            r_first[r_slot] <= 1'b1;
                        end else begin
                            r_busy[r_slot] <= 1'b0;
                            r_done[r_slot] <= 1'b1;
                        end
                    end else begin
                        r_nib[r_slot] <= w_exit_nib + (AW+1)'(1);
                    end
                end
                if (r_pend_stop[w_next]) begin
                    r_busy[w_next] <= 1'b0;
                end else if (w_load) begin
                    r_nib[w_next]   <= {w_start[w_next], 1'b0};
                    r_busy[w_next]  <= 1'b1;
                    r_first[w_next] <= 1'b1;
                    r_loop[w_next]  <= loop[w_next];
                end
                r_rom_addr <= w_load ? w_start[w_next] : r_nib[w_next][AW:1];
            end
        end
    end

    assign rom_addr   = r_rom_addr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pipe_en    = r_pipe_en;
    assign pipe_first = r_pipe_first;
    assign pipe_ch    = r_pipe_ch;
    assign pipe_data  = r_pipe_data;
    assign pipe_att   = r_pipe_att;

endmodule
`default_nettype wire

// File: tb/tb_jt6295_seqn.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt6295_seqn
//  Purpose  : Directed self-checking bench for jt6295_seqn (4-ch and 6-ch).
//  Revision : 1.0  initial release
// ============================================================================
module tb_jt6295_seqn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel, 18-bit instance
    logic        rst, cen, rom_ok;
    logic [3:0]  start, stop, loop, busy, done;
    logic [71:0] start_addr, stop_addr;
    logic [15:0] att;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        pipe_en, pipe_first;
    logic [1:0]  pipe_ch;
    logic [3:0]  pipe_data, pipe_att;

    // 6-channel, 20-bit instance
    logic         b_rst, b_cen;
    logic [5:0]   b_start, b_stop, b_loop, b_busy, b_done;
    logic [119:0] b_start_addr, b_stop_addr;
    logic [23:0]  b_att;
    logic [19:0]  b_rom_addr;
    logic         b_pipe_en, b_pipe_first;
    logic [2:0]   b_pipe_ch;
    logic [3:0]   b_pipe_data, b_pipe_att;

    function automatic logic [7:0] rom_fn(input logic [17:0] a);
        if (a == 18'h100)      return 8'hA5;
        else if (a == 18'h101) return 8'h3C;
        else                   return {a[3:0], ~a[3:0]};
    endfunction

    function automatic logic [19:0] b_st(input int k);
        return 20'(k) * 20'h10000 + 20'h40;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    jt6295_seqn #(.NCH(4), .CW(2), .AW(18)) dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .stop(stop), .loop(loop),
        .start_addr(start_addr), .stop_addr(stop_addr), .att(att),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .busy(busy), .done(done), .pipe_en(pipe_en), .pipe_first(pipe_first),
        .pipe_ch(pipe_ch), .pipe_data(pipe_data), .pipe_att(pipe_att)
    );

    jt6295_seqn #(.NCH(6), .CW(3), .AW(20)) dut_b (
        .clk(clk), .rst(b_rst), .cen(b_cen), .start(b_start), .stop(b_stop), .loop(b_loop),
        .start_addr(b_start_addr), .stop_addr(b_stop_addr), .att(b_att),
        .rom_addr(b_rom_addr), .rom_data(b_rom_addr[7:0]), .rom_ok(1'b1),
        .busy(b_busy), .done(b_done), .pipe_en(b_pipe_en), .pipe_first(b_pipe_first),
        .pipe_ch(b_pipe_ch), .pipe_data(b_pipe_data), .pipe_att(b_pipe_att)
    );

    typedef struct {
        logic [3:0]  st;
        logic        en;
        logic [1:0]  ch;
        logic [3:0]  data;
        logic        first;
        logic [3:0]  busy;
        logic [3:0]  done;
        logic [17:0] rom;
    } vec_t;

    vec_t        tbl [19];
    int          n_checks, n_err;
    logic [8:0]  ev [$];
    logic [3:0]  done_slot, done_all, busy_all;
    int          stall3, n_stall;
    int          s, c, m0s, m0c, e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One slot: cen edge, then an idle clk during which requests are pulsed
    task automatic slot(input logic [3:0] st, input logic [3:0] sp);
        rom_ok = 1'b1;
        if (stall3 > 0 && pipe_ch == 2'd2) begin
            rom_ok = 1'b0;
            stall3--;
        end
        cen = 1'b1;
        @(posedge clk); #1;
        done_slot = done;
        done_all  = done_all | done;
        cen    = 1'b0;
        rom_ok = 1'b1;
        start  = st;
        stop   = sp;
        @(posedge clk); #1;
        start = '0;
        stop  = '0;
        busy_all = busy_all | busy;
        if (pipe_en) ev.push_back({pipe_first, 2'b00, pipe_ch, pipe_data});
        if (pipe_ch == 2'd3 && !pipe_en && busy[3]) n_stall++;
    endtask

    task automatic check_seq(input string name, input int ch, input logic [31:0] exp,
                             input int n, input logic [7:0] fm, input bit exact);
        int k;
        k = 0;
        foreach (ev[i]) begin
            if (ev[i][7:4] == 4'(ch)) begin
                if (k < n) begin
                    chk({name, "_nib"}, 32'(ev[i][3:0]), 32'(exp[4*(n-1-k) +: 4]));
                    chk({name, "_first"}, 32'(ev[i][8]), 32'(fm[n-1-k]));
                end
                k++;
            end
        end
        if (exact) chk({name, "_cnt"}, k, n);
        else       chk({name, "_cnt_min"}, 32'(k >= n), 32'd1);
    endtask

    initial begin
        n_checks = 0; n_err = 0; stall3 = 0; n_stall = 0;
        done_all = '0; busy_all = '0; done_slot = '0;
        rst = 1'b1; cen = 1'b0; rom_ok = 1'b1;
        start = '0; stop = '0; loop = '0;
        start_addr = {18'h00300, 18'h00100, 18'h00200, 18'h00312};
        stop_addr  = {18'h00301, 18'h00101, 18'h00203, 18'h00313};
        att        = 16'h7531;
        b_rst = 1'b1; b_cen = 1'b0; b_start = '0; b_stop = '0; b_loop = '0;
        b_att = 24'h543210;
        for (int k = 0; k < 6; k++) begin
            b_start_addr[k*20 +: 20] = b_st(k);
            b_stop_addr[k*20 +: 20]  = b_st(k) + 20'h100;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pipe_en", 32'(pipe_en), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_pipe_ch", 32'(pipe_ch), 0);

        // Single-shot playback of ch2: A,5,3,C then done
        for (int i = 0; i < 19; i++) begin
            tbl[i].st    = '0;
            tbl[i].en    = 1'b0;
            tbl[i].ch    = 2'(i % 4);
            tbl[i].data  = '0;
            tbl[i].first = 1'b0;
            tbl[i].busy  = (i >= 1 && i <= 13) ? 4'b0100 : 4'b0000;
            tbl[i].done  = '0;
            tbl[i].rom   = '0;
        end
        tbl[0].st = 4'b0100;
        tbl[2].en = 1'b1;  tbl[2].data  = 4'hA; tbl[2].first = 1'b1;
        tbl[6].en = 1'b1;  tbl[6].data  = 4'h5;
        tbl[10].en = 1'b1; tbl[10].data = 4'h3;
        tbl[14].en = 1'b1; tbl[14].data = 4'hC; tbl[14].done = 4'b0100;
        tbl[1].rom = 18'h100; tbl[5].rom = 18'h100;
        tbl[9].rom = 18'h101; tbl[13].rom = 18'h101; tbl[17].rom = 18'h101;

        for (int i = 0; i < 19; i++) begin
            slot(tbl[i].st, 4'b0000);
            chk($sformatf("t1_ch[%0d]", i), 32'(pipe_ch), 32'(tbl[i].ch));
            chk($sformatf("t1_en[%0d]", i), 32'(pipe_en), 32'(tbl[i].en));
            if (tbl[i].en) begin
                chk($sformatf("t1_data[%0d]", i), 32'(pipe_data), 32'(tbl[i].data));
                chk($sformatf("t1_first[%0d]", i), 32'(pipe_first), 32'(tbl[i].first));
            end
            chk($sformatf("t1_att[%0d]", i), 32'(pipe_att), 32'(tbl[i].ch) * 2 + 1);
            chk($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("t1_done[%0d]", i), 32'(done_slot), 32'(tbl[i].done));
            chk($sformatf("t1_rom[%0d]", i), 32'(rom_addr), 32'(tbl[i].rom));
        end
        chk("t1_done_width", 32'(done), 0);

        // Looping playback of ch2, then stop
        loop = 4'b0100; ev.delete(); done_all = '0;
        slot(4'b0100, 4'b0000);
        repeat (40) slot(4'b0000, 4'b0000);
        check_seq("loop", 2, 32'hA53CA53C, 8, 8'b10001000, 1'b0);
        chk("loop_nodone", 32'(done_all), 0);
        chk("loop_busy", 32'(busy[2]), 1);
        slot(4'b0000, 4'b0100);
        repeat (4) slot(4'b0000, 4'b0000);
        chk("stop_busy", 32'(busy[2]), 0);
        ev.delete();
        repeat (8) slot(4'b0000, 4'b0000);
        check_seq("after_stop", 2, 32'h0, 0, 8'h00, 1'b1);
        loop = '0;

        // Start on a busy channel is discarded; start+stop on idle ch0
        ev.delete(); done_all = '0; busy_all = '0;
        slot(4'b0010, 4'b0000);
        repeat (6) slot(4'b0000, 4'b0000);
        slot(4'b0011, 4'b0001);
        repeat (40) slot(4'b0000, 4'b0000);
        check_seq("ign", 1, 32'h0F1E2D3C, 8, 8'b10000000, 1'b1);
        chk("ign_busy0", 32'(busy_all[0]), 0);
        chk("ign_done", 32'(done_all), 32'h2);
        chk("ign_idle", 32'(busy), 0);

        // ROM stall on ch3 for two periods, ch0 unaffected
        ev.delete(); done_all = '0; n_stall = 0;
        slot(4'b1001, 4'b0000);
        for (int i = 0; i < 8 && busy[3] !== 1'b1; i++) slot(4'b0000, 4'b0000);
        stall3 = 2;
        repeat (30) slot(4'b0000, 4'b0000);
        check_seq("stall3", 3, 32'h00000F1E, 4, 8'b00001000, 1'b1);
        check_seq("stall0", 0, 32'h00002D3C, 4, 8'b00001000, 1'b1);
        chk("stall_cnt", n_stall, 2);
        chk("stall_done", 32'(done_all), 32'h9);
        chk("stall_idle", 32'(busy), 0);

        // Six channels, non-power-of-two wrap
        b_rst = 1'b0;
        b_start = 6'h3F;
        @(posedge clk); #1;
        b_start = '0;
        for (int m = 1; m <= 14; m++) begin
            b_cen = 1'b1;
            @(posedge clk); #1;
            b_cen = 1'b0;
            s   = m % 6;
            c   = (m - 1) % 6;
            m0s = (s == 0) ? 6 : s;
            m0c = (c == 0) ? 6 : c;
            e   = (m - m0s) / 6;
            chk($sformatf("b_ch[%0d]", m), 32'(b_pipe_ch), c);
            chk($sformatf("b_en[%0d]", m), 32'(b_pipe_en), 32'(m - 1 >= m0c));
            chk($sformatf("b_rom[%0d]", m), 32'(b_rom_addr), 32'(b_st(s)) + e / 2);
            @(posedge clk); #1;
        end
        chk("b_busy_all", 32'(b_busy), 32'h3F);
        b_rst = 1'b1; b_cen = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0; b_cen = 1'b0;
        chk("b_rst_busy", 32'(b_busy), 0);
        chk("b_rst_en", 32'(b_pipe_en), 0);
        chk("b_rst_rom", 32'(b_rom_addr), 0);
        chk("b_rst_done", 32'(b_done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt6295_seqn.md
Name: jt6295_seqn

Overview:
- Parametrised, time-multiplexed ADPCM channel sequencer for the next-generation jt6295 core.
- Generalises the fixed 4-channel, 18-bit nibble fetcher in three ways:
  - NCH channels.
  - AW-bit ROM byte address.
  - Per-channel loop mode, ROM-stall tolerance and end-of-sample pulses.
- Sits between the control/phrase-table logic and the shared ADPCM decoder/accumulator. Feeds one nibble per channel slot.

Parameters:
NCH, 4, number of channels (2..16)
CW, 2, channel index width, must satisfy 2**CW >= NCH
AW, 18, ROM byte address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
cen  in  1  slot enable, one channel slot per cen pulse (NCH slots per sample period)
start  in  NCH  start request pulses, one bit per channel
stop  in  NCH  stop request pulses, one bit per channel
loop  in  NCH  loop enable, sampled when a channel starts
start_addr  in  NCH*AW  per-channel start byte address, channel k at bits [k*AW +: AW]
stop_addr  in  NCH*AW  per-channel inclusive last byte address
att  in  NCH*4  per-channel attenuation code
rom_addr  out  AW  ROM byte address
rom_data  in  8  ROM data
rom_ok  in  1  rom_data valid for current rom_addr
busy  out  NCH  channel playing
done  out  NCH  one-clk pulse when a channel ends without looping
pipe_en  out  1  pipe nibble valid
pipe_first  out  1  first nibble of a (re)started sample; decoder resets predictor/step
pipe_ch  out  CW  channel of pipe nibble
pipe_data  out  4  ADPCM nibble
pipe_att  out  4  attenuation for pipe_ch

Behaviour:
- Reset: every output is 0; slot counter, internal per-channel nibble addresses, pending start/stop and loop latches are 0.
- Reset mid-playback silences all channels on the next clk. No done pulses are generated by reset.
- Slot counter
  - Advances on each cen: 0..NCH-1, then wraps to 0.
  - A non-power-of-two NCH wraps at NCH-1.
- Request capture
  - start/stop bits are captured into sticky pending registers on any clk, independent of cen.
  - A pulse shorter than one slot is never lost.
- Slot entry (on cen, slot becomes k):
  - pending stop[k] set: busy[k] <= 0; both pendings for k cleared. Stop wins over a simultaneous start.
  - else pending start[k] set and busy[k]=0:
    - nib_addr[k] <= {start_addr[k],1'b0}
    - busy[k] <= 1
    - first[k] <= 1
    - loop latch[k] <= loop[k]
    - pending start cleared
  - else pending start[k] set and busy[k]=1: request discarded (OKI semantics).
  - rom_addr <= nib_addr[k][AW:1], using the address after any load above.
- Slot exit (next cen, slot k ends). pipe_ch <= k and pipe_att <= att[k] always.
  - busy[k]=1 and rom_ok=1:
    - pipe_en <= 1.
    - pipe_data <= high nibble if nib_addr[k][0]=0, else low nibble.
    - pipe_first <= first[k]; first[k] <= 0.
    - Advance nib_addr[k] by 1, except at the end case below.
  - busy[k]=1, rom_ok=0 (stall): pipe_en <= 0; address and first flag held; nibble retried next period.
  - busy[k]=0: pipe_en <= 0, pipe_first <= 0.
- Pipe outputs stay stable for one full slot.
- End of sample: the low nibble of byte stop_addr[k] was just emitted.
  - loop latch=1: nib_addr[k] <= {start_addr[k],0}, first[k] <= 1, busy stays 1.
  - loop latch=0: busy[k] <= 0; done[k] pulses for exactly one clk, coincident with the cen.
- stop_addr < start_addr: the channel plays until the nibble address wraps modulo 2**(AW+1) and reaches stop_addr. No special handling.
- Simultaneous stop pending and end in the same slot: the stop is applied at the next entry; the end is handled normally.
- start_addr, stop_addr and att are read live. Software holds them stable while a channel is busy.

Test Plan:
- NCH=4, AW=18. Start ch2, start_addr=0x100, stop_addr=0x101, rom returns 0xA5 then 0x3C, rom_ok=1.
  - pipe_ch=2 nibbles are A,5,3,C; pipe_first=1 only on A.
  - done[2] pulses once, then busy[2]=0.
- Same setup with loop[2]=1.
  - Nibble sequence repeats A,5,3,C,A…; pipe_first=1 on every A.
  - done never pulses.
  - A stop pulse ends the sequence at the next ch2 slot entry.
- ch1 playing; 1-clk start[1] pulse arrives between cen pulses → ignored, address sequence uninterrupted.
  - Start+stop in the same clk on idle ch0 → busy[0] stays 0.
- rom_ok held low for ch3's slot, two sample periods → ch3 pipe_en=0 for those slots.
  - Next valid slot emits the same pending nibble; other channels unaffected.
- NCH=6, AW=20. Start all channels on distinct addresses.
  - Slot order is 0..5 then 0; rom_addr tracks each channel.
  - Reset asserted mid-stream → next clk busy=0, pipe_en=0, rom_addr=0.
